trig_sched: RTL

TRIG_SCHED -- requirements
Module: trig_sched

---
 rtl/trig_sched.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/trig_sched.sv
// trig_sched: trigger scheduler in front of the URAM event buffer.
// Accepts a trigger when running, idle and the event buffer has room,
// presents {1'b0, trig_time} plus its event number as one AXI4-Stream beat,
// then enforces HOLDOFF cycles of dead time before the next trigger.
// Optional feature: define TRIG_SCHED_DROP_COUNT_EN to build the rejected
// trigger counter; without it drop_count_o is tied to zero.
module trig_sched #(
    parameter int unsigned NBUF    = 4,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic        aclk_i,
    input  logic        aresetn_i,
    input  logic        run_i,
    input  logic        clr_i,
    input  logic [14:0] trig_time_i,
    input  logic        trig_valid_i,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] evt_num_o,
    input  logic        done_i,
    output logic [3:0]  occupancy_o,
    output logic [15:0] drop_count_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [3:0] NBUF_C      = 4'(NBUF);
    localparam logic [7:0] HOLDOFF_C   = 8'(HOLDOFF);
    localparam logic [7:0] HOLD_LOAD_C = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);

    logic [1:0]  rst_sync_r;
    logic        rst_n_s;
    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [7:0]  hold_cnt_r;
    logic [15:0] tdata_r;
    logic        tvalid_r;
    logic [15:0] evt_num_r;
    logic [15:0] evt_cnt_r;
    logic [3:0]  occ_r;
    logic        err_r;
    logic        busy_r;
    logic        accept_s;
    logic        hs_s;
    logic        drop_s;

    // Reset bridge: assert asynchronously, release two edges after aresetn_i rises.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Accept, handshake and reject decode; accept sees registered occupancy only.
    always_comb begin
        accept_s = trig_valid_i & run_i & (state_r == ST_IDLE) & (occ_r < NBUF_C);
        hs_s     = tvalid_r & m_axis_tready;
        drop_s   = trig_valid_i & ~accept_s;
    end

    // Next-state logic for the IDLE -> ISSUE -> HOLD -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (hs_s) begin
                    state_nxt_s = (HOLDOFF_C == 8'd0) ? ST_IDLE : ST_HOLD;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and dead-time counter; clr_i deliberately leaves both alone.
    always_ff @(posedge aclk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_ISSUE) && hs_s) begin
                hold_cnt_r <= HOLD_LOAD_C;
            end else if ((state_r == ST_HOLD) && (hold_cnt_r != 8'd0)) begin
                hold_cnt_r <= hold_cnt_r - 8'd1;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // Output beat: latched on accept, held until the handshake retires it.
    always_ff @(posedge aclk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            tvalid_r  <= 1'b0;
            tdata_r   <= 16'd0;
            evt_num_r <= 16'd0;
        end else if (accept_s) begin
            tvalid_r  <= 1'b1;
            tdata_r   <= {1'b0, trig_time_i};
            evt_num_r <= evt_cnt_r;
        end else if (hs_s) begin
            tvalid_r  <= 1'b0;
        end else begin
            tvalid_r  <= tvalid_r;
        end
    end

    // Event counter: advances on each handshake, wraps at 16 bits, clear wins.
    always_ff @(posedge aclk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            evt_cnt_r <= 16'd0;
        end else if (clr_i) begin
            evt_cnt_r <= 16'd0;
        end else if (hs_s) begin
            evt_cnt_r <= evt_cnt_r + 16'd1;
        end else begin
            evt_cnt_r <= evt_cnt_r;
        end
    end

    // Outstanding events: +1 per issued beat, -1 per completed readout, floor at 0.
    always_ff @(posedge aclk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            occ_r <= 4'd0;
        end else begin
            case ({hs_s, done_i})
                2'b10: occ_r <= occ_r + 4'd1;
                2'b01: occ_r <= (occ_r != 4'd0) ? (occ_r - 4'd1) : 4'd0;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Sticky underflow flag: a completion with nothing outstanding.
    always_ff @(posedge aclk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            err_r <= 1'b0;
        end else if (clr_i) begin
            err_r <= 1'b0;
        end else if (done_i && !hs_s && (occ_r == 4'd0)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Busy is registered from the next state so it tracks state_r exactly.
    always_ff @(posedge aclk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

`ifdef TRIG_SCHED_DROP_COUNT_EN
    logic [15:0] drop_cnt_r;

    // Rejected-trigger counter, saturating at 0xFFFF; clear wins over increment.
    always_ff @(posedge aclk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            drop_cnt_r <= 16'd0;
        end else if (clr_i) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_count_o = drop_cnt_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
    assign drop_count_o  = 16'd0;
`endif

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign evt_num_o     = evt_num_r;
    assign occupancy_o   = occ_r;
    assign busy_o        = busy_r;
    assign err_o         = err_r;

endmodule
